mem_resp: RTL and testbench

- Valid/ready memory responder on the target side of the core's fetch/load-store bus.
- Serves word reads and byte-strobed writes from a local word array, with fixed, parameterised latency.
- Replaces the combinational DPI memory once the core moves to handshaked multi-cycle IFU/LSU.
- Read and write channels are independent; each has one outstanding transaction at most.

---
 rtl/mem_resp_pkg.sv | 17 +
 rtl/mem_resp_array.sv | 37 +++
 rtl/mem_resp.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_resp.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared response codes and FSM state encodings for the mem_resp responder.
package mem_resp_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef logic [1:0] rd_state_t;
   localparam rd_state_t R_IDLE = 2'd0;
   localparam rd_state_t R_WAIT = 2'd1;
   localparam rd_state_t R_RESP = 2'd2;

   typedef logic [1:0] wr_state_t;
   localparam wr_state_t W_IDLE = 2'd0;
   localparam wr_state_t W_WAIT = 2'd1;
   localparam wr_state_t W_RESP = 2'd2;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_resp: one registered read port with enable and one
// byte-strobed write port on the same clock. Same-index collisions return the
// pre-write contents.
module mem_resp_array #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IW          = 10
) (
   input  logic              clk,
   input  logic              rd_en,
   input  logic [IW-1:0]     rd_idx,
   output logic [XLEN-1:0]   rd_data,
   input  logic              wr_en,
   input  logic [IW-1:0]     wr_idx,
   input  logic [XLEN-1:0]   wr_data,
   input  logic [XLEN/8-1:0] wr_strb
);

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   // Registered read; the nonblocking update gives read-before-write ordering.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
   end

   // Byte-lane write under strobe.
   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < XLEN/8; b++) begin
         if (wr_en && wr_strb[b]) begin
            mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/mem_resp.sv
// Valid/ready memory responder: independent read and write channels, one
// outstanding transaction each, fixed latency, SLVERR outside the window.
module mem_resp
   import mem_resp_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     DEPTH_WORDS = 1024,
   parameter logic [XLEN-1:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned     RD_LAT      = 2,
   parameter int unsigned     WR_LAT      = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ar_valid_i,
   output logic              ar_ready_o,
   input  logic [XLEN-1:0]   ar_addr_i,
   output logic              r_valid_o,
   input  logic              r_ready_i,
   output logic [XLEN-1:0]   r_data_o,
   output logic [1:0]        r_resp_o,
   input  logic              aw_valid_i,
   output logic              aw_ready_o,
   input  logic [XLEN-1:0]   aw_addr_i,
   input  logic              w_valid_i,
   output logic              w_ready_o,
   input  logic [XLEN-1:0]   w_data_i,
   input  logic [XLEN/8-1:0] w_strb_i,
   output logic              b_valid_o,
   input  logic              b_ready_i,
   output logic [1:0]        b_resp_o
);

   localparam int unsigned     IW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned     SW      = XLEN / 8;
   localparam logic [XLEN:0]   SPAN    = (XLEN+1)'(DEPTH_WORDS) << 2;
   localparam int unsigned     RCW     = $clog2(RD_LAT + 1);
   localparam int unsigned     WCW     = $clog2(WR_LAT + 1);
   localparam logic [RCW-1:0]  RD_LOAD = RCW'((RD_LAT >= 2) ? RD_LAT - 2 : 0);
   localparam logic [WCW-1:0]  WR_LOAD = WCW'((WR_LAT >= 2) ? WR_LAT - 2 : 0);

   // Read channel state
   rd_state_t       rd_state;
   logic [RCW-1:0]  rd_cnt;
   logic [XLEN-1:0] rd_addr_q;
   logic [XLEN-1:0] rd_addr;
   logic [XLEN-1:0] rd_off;
   logic            rd_hit;
   logic            rd_enter;
   logic            rd_en;
   logic            r_ok_q;
   logic            r_err_q;
   logic [XLEN-1:0] arr_rdata;

   // Write channel state
   wr_state_t       wr_state;
   logic [WCW-1:0]  wr_cnt;
   logic            aw_got_q;
   logic            w_got_q;
   logic [XLEN-1:0] wr_addr_q;
   logic [XLEN-1:0] wr_data_q;
   logic [SW-1:0]   wr_strb_q;
   logic [XLEN-1:0] wr_addr;
   logic [XLEN-1:0] wr_data;
   logic [SW-1:0]   wr_strb;
   logic [XLEN-1:0] wr_off;
   logic            wr_hit;
   logic            wr_both;
   logic            wr_enter;
   logic            wr_en;
   logic            b_err_q;

   // Read decode: with RD_LAT=1 the array is sampled on the accept edge, so
   // the live address is used while idle and the latched one afterwards.
   always_comb begin
      rd_addr  = (rd_state == R_IDLE) ? ar_addr_i : rd_addr_q;
      rd_off   = rd_addr - BASE_ADDR;
      rd_hit   = ({1'b0, rd_off} < SPAN);
      rd_enter = 1'b0;
      if (rd_state == R_IDLE) begin
         rd_enter = ar_valid_i && (RD_LAT == 1);
      end else if (rd_state == R_WAIT) begin
         rd_enter = (rd_cnt == '0);
      end
      rd_en = rd_enter && rd_hit && !rst_i;
   end

   // Read FSM: accept, count down the latency, hold the response until taken.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_state  <= R_IDLE;
         rd_cnt    <= '0;
         rd_addr_q <= '0;
         r_ok_q    <= 1'b0;
         r_err_q   <= 1'b0;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (ar_valid_i) begin
                  rd_addr_q <= ar_addr_i;
                  if (RD_LAT == 1) begin
                     rd_state <= R_RESP;
                     r_ok_q   <= rd_hit;
                     r_err_q  <= !rd_hit;
                  end else begin
                     rd_state <= R_WAIT;
                     rd_cnt   <= RD_LOAD;
                  end
               end
            end
            R_WAIT: begin
               if (rd_cnt == '0) begin
                  rd_state <= R_RESP;
                  r_ok_q   <= rd_hit;
                  r_err_q  <= !rd_hit;
               end else begin
                  rd_cnt <= rd_cnt - 1'b1;
               end
            end
            R_RESP: begin
               if (r_ready_i) begin
                  rd_state <= R_IDLE;
                  r_ok_q   <= 1'b0;
                  r_err_q  <= 1'b0;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   // Write decode: each half uses its captured copy once held, else the live bus.
   always_comb begin
      wr_addr  = aw_got_q ? wr_addr_q : aw_addr_i;
      wr_data  = w_got_q  ? wr_data_q : w_data_i;
      wr_strb  = w_got_q  ? wr_strb_q : w_strb_i;
      wr_off   = wr_addr - BASE_ADDR;
      wr_hit   = ({1'b0, wr_off} < SPAN);
      wr_both  = (wr_state == W_IDLE) && (aw_got_q || aw_valid_i) && (w_got_q || w_valid_i);
      wr_enter = 1'b0;
      if (wr_state == W_IDLE) begin
         wr_enter = wr_both && (WR_LAT == 1);
      end else if (wr_state == W_WAIT) begin
         wr_enter = (wr_cnt == '0);
      end
      wr_en = wr_enter && wr_hit && !rst_i;
   end

   // Write FSM: capture AW and W independently, then wait and respond.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_state  <= W_IDLE;
         wr_cnt    <= '0;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_strb_q <= '0;
         b_err_q   <= 1'b0;
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (aw_valid_i && !aw_got_q) begin
                  aw_got_q  <= 1'b1;
                  wr_addr_q <= aw_addr_i;
               end
               if (w_valid_i && !w_got_q) begin
                  w_got_q   <= 1'b1;
                  wr_data_q <= w_data_i;
                  wr_strb_q <= w_strb_i;
               end
               if (wr_both) begin
                  if (WR_LAT == 1) begin
                     wr_state <= W_RESP;
                     b_err_q  <= !wr_hit;
                  end else begin
                     wr_state <= W_WAIT;
                     wr_cnt   <= WR_LOAD;
                  end
               end
            end
            W_WAIT: begin
               if (wr_cnt == '0) begin
                  wr_state <= W_RESP;
                  b_err_q  <= !wr_hit;
               end else begin
                  wr_cnt <= wr_cnt - 1'b1;
               end
            end
            W_RESP: begin
               if (b_ready_i) begin
                  wr_state <= W_IDLE;
                  aw_got_q <= 1'b0;
                  w_got_q  <= 1'b0;
                  b_err_q  <= 1'b0;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   mem_resp_array #(
      .XLEN        (XLEN),
      .DEPTH_WORDS (DEPTH_WORDS),
      .IW          (IW)
   ) u_array (
      .clk     (clk_i),
      .rd_en   (rd_en),
      .rd_idx  (rd_off[IW+1:2]),
      .rd_data (arr_rdata),
      .wr_en   (wr_en),
      .wr_idx  (wr_off[IW+1:2]),
      .wr_data (wr_data),
      .wr_strb (wr_strb)
   );

   // Array output is unresettable, so zero it unless an in-range response is held.
   assign r_data_o   = r_ok_q ? arr_rdata : '0;
   assign r_resp_o   = r_err_q ? RESP_SLVERR : RESP_OKAY;
   assign r_valid_o  = (rd_state == R_RESP);
   assign ar_ready_o = (rd_state == R_IDLE);

   assign b_resp_o   = b_err_q ? RESP_SLVERR : RESP_OKAY;
   assign b_valid_o  = (wr_state == W_RESP);
   assign aw_ready_o = (wr_state == W_IDLE) && !aw_got_q;
   assign w_ready_o  = (wr_state == W_IDLE) && !w_got_q;

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: vector table plus hand-built corner sequences,
// with read/write responses checked from expectation queues.
module tb_mem_resp;

   localparam int unsigned RD_LAT = 2;
   localparam int unsigned WR_LAT = 1;
   localparam logic [1:0]  OK     = 2'b00;
   localparam logic [1:0]  ERR    = 2'b10;
   localparam int          NV     = 16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        ar_valid_i, ar_ready_o;
   logic [31:0] ar_addr_i;
   logic        r_valid_o, r_ready_i;
   logic [31:0] r_data_o;
   logic [1:0]  r_resp_o;
   logic        aw_valid_i, aw_ready_o;
   logic [31:0] aw_addr_i;
   logic        w_valid_i, w_ready_o;
   logic [31:0] w_data_i;
   logic [3:0]  w_strb_i;
   logic        b_valid_o, b_ready_i;
   logic [1:0]  b_resp_o;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      string       nm;
   } exp_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   exp_t rq[$];
   exp_t wq[$];
   exp_t mon_r;
   exp_t mon_b;
   vec_t vecs[NV];
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_resp #(
      .XLEN        (32),
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h8000_0000),
      .RD_LAT      (RD_LAT),
      .WR_LAT      (WR_LAT)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .ar_valid_i (ar_valid_i),
      .ar_ready_o (ar_ready_o),
      .ar_addr_i  (ar_addr_i),
      .r_valid_o  (r_valid_o),
      .r_ready_i  (r_ready_i),
      .r_data_o   (r_data_o),
      .r_resp_o   (r_resp_o),
      .aw_valid_i (aw_valid_i),
      .aw_ready_o (aw_ready_o),
      .aw_addr_i  (aw_addr_i),
      .w_valid_i  (w_valid_i),
      .w_ready_o  (w_ready_o),
      .w_data_i   (w_data_i),
      .w_strb_i   (w_strb_i),
      .b_valid_o  (b_valid_o),
      .b_ready_i  (b_ready_i),
      .b_resp_o   (b_resp_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // Pop and compare an expectation whenever a response handshake is about to occur.
   always @(negedge clk_i) begin
      if (!rst_i && r_valid_o && r_ready_i) begin
         if (rq.size() == 0) begin
            check("r_unexpected", 32'(r_valid_o), 32'd0);
         end else begin
            mon_r = rq.pop_front();
            check({mon_r.nm, "_rdata"}, r_data_o, mon_r.data);
            check({mon_r.nm, "_rresp"}, 32'(r_resp_o), 32'(mon_r.resp));
         end
      end
      if (!rst_i && b_valid_o && b_ready_i) begin
         if (wq.size() == 0) begin
            check("b_unexpected", 32'(b_valid_o), 32'd0);
         end else begin
            mon_b = wq.pop_front();
            check({mon_b.nm, "_bresp"}, 32'(b_resp_o), 32'(mon_b.resp));
         end
      end
   end

   task automatic check_idle(input string p);
      check({p, "_ar_ready"}, 32'(ar_ready_o), 32'd1);
      check({p, "_aw_ready"}, 32'(aw_ready_o), 32'd1);
      check({p, "_w_ready"},  32'(w_ready_o),  32'd1);
      check({p, "_r_valid"},  32'(r_valid_o),  32'd0);
      check({p, "_b_valid"},  32'(b_valid_o),  32'd0);
      check({p, "_r_data"},   r_data_o,        32'd0);
      check({p, "_r_resp"},   32'(r_resp_o),   32'd0);
      check({p, "_b_resp"},   32'(b_resp_o),   32'd0);
   endtask

   // Entered just after the accept/commit edge; counts edges until valid shows.
   task automatic wait_resp(input bit is_b, input int lat, input string nm);
      int k;
      bit seen;
      k    = 1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_i);
         seen = is_b ? b_valid_o : r_valid_o;
         if (!seen) begin
            @(posedge clk_i);
            #1;
            k++;
         end
      end
      check({nm, "_lat"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(lat));
   endtask

   task automatic drain(input string nm);
      @(posedge clk_i);
      #1;
      check({nm, "_drain"}, 32'(rq.size() + wq.size()), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input string nm);
      bit acc;
      rq.push_back('{ed, er, nm});
      ar_valid_i = 1'b1;
      ar_addr_i  = a;
      acc        = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk_i);
         acc = ar_ready_o;
         @(posedge clk_i);
         #1;
      end
      ar_valid_i = 1'b0;
      check({nm, "_ar_accept"}, 32'(acc), 32'd1);
      wait_resp(1'b0, RD_LAT, nm);
      drain(nm);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input string nm);
      bit awf, wf, aw_done, w_done;
      wq.push_back('{32'd0, er, nm});
      aw_valid_i = 1'b1;
      aw_addr_i  = a;
      w_valid_i  = 1'b1;
      w_data_i   = d;
      w_strb_i   = s;
      aw_done    = 1'b0;
      w_done     = 1'b0;
      for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
         @(negedge clk_i);
         awf = aw_valid_i && aw_ready_o;
         wf  = w_valid_i && w_ready_o;
         @(posedge clk_i);
         #1;
         if (awf) begin aw_valid_i = 1'b0; aw_done = 1'b1; end
         if (wf)  begin w_valid_i  = 1'b0; w_done  = 1'b1; end
      end
      aw_valid_i = 1'b0;
      w_valid_i  = 1'b0;
      check({nm, "_aw_w_accept"}, 32'(aw_done && w_done), 32'd1);
      wait_resp(1'b1, WR_LAT, nm);
      drain(nm);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h8000_0000, 32'h0123_4567, 4'hF, 32'h0,          OK};
      vecs[1]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0123_4567,  OK};
      vecs[2]  = '{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0,          OK};
      vecs[3]  = '{1'b0, 32'h8000_0FFE, 32'h0,         4'h0, 32'hCAFE_F00D,  OK};
      vecs[4]  = '{1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0,          ERR};
      vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0123_4567,  OK};
      vecs[6]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,          ERR};
      vecs[7]  = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 32'h0,          ERR};
      vecs[8]  = '{1'b1, 32'h8000_0FFC, 32'h0,         4'h0, 32'h0,          OK};
      vecs[9]  = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D,  OK};
      vecs[10] = '{1'b1, 32'h8000_0004, 32'h1111_1111, 4'hF, 32'h0,          OK};
      vecs[11] = '{1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'h8, 32'h0,          OK};
      vecs[12] = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hAA11_1111,  OK};
      vecs[13] = '{1'b1, 32'h8000_0020, 32'h0,         4'hF, 32'h0,          OK};
      vecs[14] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,          OK};
      vecs[15] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF,  OK};

      rst_i      = 1'b0;
      ar_valid_i = 1'b0; ar_addr_i = '0;
      aw_valid_i = 1'b0; aw_addr_i = '0;
      w_valid_i  = 1'b0; w_data_i  = '0; w_strb_i = '0;
      r_ready_i  = 1'b1; b_ready_i = 1'b1;

      #1 rst_i = 1'b1;
      #2 check_idle("reset");
      @(negedge clk_i) rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].wr)
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, $sformatf("v%0d", i));
         else
            do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, $sformatf("v%0d", i));
      end

      // W two cycles ahead of AW, partial strobes over 0xDEADBEEF.
      wq.push_back('{32'd0, OK, "strb"});
      w_valid_i = 1'b1; w_data_i = 32'h1122_3344; w_strb_i = 4'b0101;
      @(negedge clk_i);
      check("strb_w_ready_pre", 32'(w_ready_o), 32'd1);
      @(posedge clk_i); #1; w_valid_i = 1'b0;
      @(negedge clk_i);
      check("strb_w_ready_drop", 32'(w_ready_o), 32'd0);
      check("strb_aw_ready_hold", 32'(aw_ready_o), 32'd1);
      check("strb_b_idle", 32'(b_valid_o), 32'd0);
      @(posedge clk_i); #1;
      aw_valid_i = 1'b1; aw_addr_i = 32'h8000_0010;
      @(negedge clk_i);
      @(posedge clk_i); #1; aw_valid_i = 1'b0;
      wait_resp(1'b1, WR_LAT, "strb");
      drain("strb");

      // Backpressure on R while reading back the strobed word.
      r_ready_i = 1'b0;
      rq.push_back('{32'hDE22_BE44, OK, "bp"});
      ar_valid_i = 1'b1; ar_addr_i = 32'h8000_0010;
      @(negedge clk_i);
      check("bp_ar_ready_pre", 32'(ar_ready_o), 32'd1);
      @(posedge clk_i); #1; ar_valid_i = 1'b0;
      wait_resp(1'b0, RD_LAT, "bp");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i); #1;
         @(negedge clk_i);
         check("bp_r_valid", 32'(r_valid_o), 32'd1);
         check("bp_r_data", r_data_o, 32'hDE22_BE44);
         check("bp_r_resp", 32'(r_resp_o), 32'(OK));
         check("bp_ar_ready", 32'(ar_ready_o), 32'd0);
      end
      @(posedge clk_i); #1; r_ready_i = 1'b1;
      @(negedge clk_i);
      @(posedge clk_i); #1;
      check("bp_ar_ready_after", 32'(ar_ready_o), 32'd1);
      check("bp_r_valid_after", 32'(r_valid_o), 32'd0);
      check("bp_drain", 32'(rq.size()), 32'd0);

      // Read and write of the same word committing on one edge.
      rq.push_back('{32'h0, OK, "col_old"});
      wq.push_back('{32'h0, OK, "col_b"});
      ar_valid_i = 1'b1; ar_addr_i = 32'h8000_0020;
      @(negedge clk_i);
      check("col_ar_ready", 32'(ar_ready_o), 32'd1);
      @(posedge clk_i); #1; ar_valid_i = 1'b0;
      aw_valid_i = 1'b1; aw_addr_i = 32'h8000_0020;
      w_valid_i  = 1'b1; w_data_i  = 32'hA5A5_A5A5; w_strb_i = 4'hF;
      @(negedge clk_i);
      check("col_aw_ready", 32'(aw_ready_o), 32'd1);
      check("col_w_ready", 32'(w_ready_o), 32'd1);
      @(posedge clk_i); #1; aw_valid_i = 1'b0; w_valid_i = 1'b0;
      @(negedge clk_i);
      check("col_r_valid", 32'(r_valid_o), 32'd1);
      check("col_b_valid", 32'(b_valid_o), 32'd1);
      drain("col");
      do_read(32'h8000_0020, 32'hA5A5_A5A5, OK, "col_new");

      // Reset with a read response pending and a half-captured write.
      r_ready_i = 1'b0;
      rq.push_back('{32'h0, OK, "rst_r"});
      ar_valid_i = 1'b1; ar_addr_i = 32'h8000_0000;
      @(negedge clk_i);
      @(posedge clk_i); #1; ar_valid_i = 1'b0;
      aw_valid_i = 1'b1; aw_addr_i = 32'h8000_0000;
      @(negedge clk_i);
      @(posedge clk_i); #1; aw_valid_i = 1'b0;
      @(negedge clk_i);
      check("pre_rst_r_valid", 32'(r_valid_o), 32'd1);
      check("pre_rst_aw_ready", 32'(aw_ready_o), 32'd0);
      #2 rst_i = 1'b1;
      #1 check_idle("mid_rst");
      rq.delete();
      wq.delete();
      @(negedge clk_i) rst_i = 1'b0;
      @(posedge clk_i); #1; r_ready_i = 1'b1;
      wq.push_back('{32'h0, OK, "rst_b"});
      w_valid_i = 1'b1; w_data_i = 32'h5A5A_5A5A; w_strb_i = 4'hF;
      @(negedge clk_i);
      @(posedge clk_i); #1; w_valid_i = 1'b0;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("post_rst_b_valid", 32'(b_valid_o), 32'd0);
      check("post_rst_w_ready", 32'(w_ready_o), 32'd0);
      check("post_rst_aw_ready", 32'(aw_ready_o), 32'd1);
      @(posedge clk_i); #1;
      aw_valid_i = 1'b1; aw_addr_i = 32'h8000_0008;
      @(negedge clk_i);
      @(posedge clk_i); #1; aw_valid_i = 1'b0;
      wait_resp(1'b1, WR_LAT, "rst_b");
      drain("rst_b");
      do_read(32'h8000_0000, 32'h0123_4567, OK, "rst_w0");
      do_read(32'h8000_0008, 32'h5A5A_5A5A, OK, "rst_w2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1);
   end

endmodule
